// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the FIFO read-side agent: state encoding, buffer depth
// and the hold/watchdog counter sizing helper.
package fifo_reader_pkg;

    localparam logic IDLE = 1'b0;
    localparam logic ACK  = 1'b1;

    localparam int unsigned BUF_DEPTH = 2;

    typedef enum logic {
        StIdle = IDLE,
        StAck  = ACK
    } state_e;

    // Bits needed to count 0 .. max(rd_hold, timeout)-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned rd_hold,
                                              input int unsigned timeout);
        int unsigned m;
        m = (rd_hold > timeout) ? rd_hold : timeout;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/fifo_reader_buf.sv
// Two-entry in-order valid/ready buffer. Entry 0 is always the head, so the
// head word comes straight from a register. Push and pop in the same cycle are
// accepted even when full.
module fifo_reader_buf
    import fifo_reader_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [BUS_WIDTH-1:0] push_data,
    input  logic                 pop,
    output logic [BUS_WIDTH-1:0] head,
    output logic [1:0]           count,
    output logic                 not_full
);

    logic [BUS_WIDTH-1:0] mem0_q;
    logic [BUS_WIDTH-1:0] mem1_q;
    logic [1:0]           count_q;
    logic                 pop_eff;
    logic                 push_eff;

    assign pop_eff  = pop && (count_q != 2'd0);
    // Space is judged after this cycle's pop so a full buffer can refill at once.
    assign not_full = (count_q < 2'(BUF_DEPTH)) || pop_eff;
    assign push_eff = push && not_full;

    // Shift/insert entries on push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0_q  <= '0;
            mem1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            unique case ({push_eff, pop_eff})
                2'b10: begin
                    if (count_q == 2'd0) mem0_q <= push_data;
                    else                 mem1_q <= push_data;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) mem0_q <= mem1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        mem0_q <= push_data;
                    end else begin
                        mem0_q <= mem1_q;
                        mem1_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head  = mem0_q;
    assign count = count_q;

endmodule

// File: rtl/fifo_reader.sv
// Read-side agent for the 1-word clock-crossing FIFO. Captures a word when the
// FIFO reports non-empty, holds fifo_rd high until the FIFO drains (at least
// RD_HOLD cycles) and streams captured words out on dout/dout_valid/dout_ready.
// Optional ACK watchdog: define FIFO_READER_TIMEOUT_EN.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 16,
    parameter int unsigned RD_HOLD   = 2,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BUS_WIDTH-1:0] fifo_dataout,
    input  logic                 fifo_empty,
    output logic                 fifo_rd,
    output logic [BUS_WIDTH-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic [15:0]          words_rcvd,
    output logic                 timeout_err
);

    if (RD_HOLD < 1 || TIMEOUT < RD_HOLD + 1) begin : g_bad_cfg
        $error("fifo_reader: need RD_HOLD >= 1 and TIMEOUT >= RD_HOLD + 1");
    end

`ifdef FIFO_READER_TIMEOUT_EN
    localparam int unsigned    CntW     = cnt_width(RD_HOLD, TIMEOUT);
    localparam logic [CntW-1:0] ToLast  = CntW'(TIMEOUT - 1);
    localparam logic [CntW-1:0] CntLast = ToLast;
`else
    localparam int unsigned    CntW     = cnt_width(RD_HOLD, 1);
    localparam logic [CntW-1:0] CntLast = CntW'(RD_HOLD - 1);
`endif
    localparam logic [CntW-1:0] HoldLast = CntW'(RD_HOLD - 1);

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            fifo_rd_q;
    logic [15:0]     words_q;
    logic            buf_not_full;
    logic [1:0]      buf_count;
    logic            capture;
    logic            pop;

    assign pop     = dout_valid && dout_ready;
    // Only IDLE captures, so a late empty flag during ACK cannot double-push.
    assign capture = (state_q == StIdle) && !fifo_empty && buf_not_full;

`ifdef FIFO_READER_TIMEOUT_EN
    logic timeout_q;
`endif

    // Handshake FSM with hold counter, word counter and optional watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            fifo_rd_q <= 1'b0;
            words_q   <= 16'd0;
`ifdef FIFO_READER_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (capture) begin
                        words_q   <= words_q + 16'd1;
                        fifo_rd_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= StAck;
                    end
                end
                StAck: begin
                    // Saturate; only the >= comparison matters once past the hold.
                    if (cnt_q != CntLast) cnt_q <= cnt_q + CntW'(1);
                    if (fifo_empty && (cnt_q >= HoldLast)) begin
                        fifo_rd_q <= 1'b0;
                        state_q   <= StIdle;
                    end
`ifdef FIFO_READER_TIMEOUT_EN
                    else if (!fifo_empty && (cnt_q == ToLast)) begin
                        // Captured word stays in the buffer; only the handshake is abandoned.
                        timeout_q <= 1'b1;
                        fifo_rd_q <= 1'b0;
                        state_q   <= StIdle;
                    end
`endif
                end
            endcase
        end
    end

    fifo_reader_buf #(
        .BUS_WIDTH (BUS_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (capture),
        .push_data (fifo_dataout),
        .pop       (pop),
        .head      (dout),
        .count     (buf_count),
        .not_full  (buf_not_full)
    );

    assign dout_valid = (buf_count != 2'd0);
    assign fifo_rd    = fifo_rd_q;
    assign words_rcvd = words_q;

`ifdef FIFO_READER_TIMEOUT_EN
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader. The bench plays the FIFO: it offers a
// word by lowering fifo_empty and raises it again some cycles after fifo_rd
// rises. Offered words go into a scoreboard queue that a negedge monitor pops
// on every dout handshake.
module tb_fifo_reader;

    localparam int unsigned BW      = 16;
    localparam int unsigned RD_HOLD = 2;
`ifdef FIFO_READER_TIMEOUT_EN
    localparam int unsigned TIMEOUT = 8;
`else
    localparam int unsigned TIMEOUT = 64;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [BW-1:0] fifo_dataout;
    logic          fifo_empty;
    logic          fifo_rd;
    logic [BW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic [15:0]   words_rcvd;
    logic          timeout_err;

    int unsigned   n_checks = 0;
    int unsigned   n_pass   = 0;
    int unsigned   n_pops   = 0;
    logic [BW-1:0] exp_q[$];

    typedef struct {
        logic [15:0] data;
        int unsigned dly;
        logic        ready;
        logic [15:0] exp_words;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    fifo_reader #(
        .BUS_WIDTH (BW),
        .RD_HOLD   (RD_HOLD),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_dataout (fifo_dataout),
        .fifo_empty   (fifo_empty),
        .fifo_rd      (fifo_rd),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .words_rcvd   (words_rcvd),
        .timeout_err  (timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard: every accepted dout word must be the oldest offered word.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_extra: got word 0x%0h, expected none", dout);
            end else begin
                check("sb_order", {16'd0, dout}, {16'd0, exp_q.pop_front()});
                n_pops++;
            end
        end
    end

    task automatic step(input int unsigned n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rd(input logic level, input int unsigned bound, input string name,
                           output int unsigned cycles);
        cycles = 0;
        while (fifo_rd !== level && cycles < bound) begin
            step();
            cycles++;
        end
        if (fifo_rd !== level) begin
            n_checks++;
            $display("FAIL %s: fifo_rd is %b after %0d cycles, expected %b",
                     name, fifo_rd, bound, level);
        end
    endtask

    // One full FIFO round trip. pulse_ready raises dout_ready only for the capture cycle.
    task automatic send_word(input logic [15:0] data, input int unsigned dly,
                             input logic pulse_ready, input string name);
        int unsigned c;
        int unsigned high;
        int unsigned exp_high;
        exp_q.push_back(data);
        fifo_dataout = data;
        fifo_empty   = 1'b0;
        if (pulse_ready) dout_ready = 1'b1;
        wait_rd(1'b1, 20, {name, "_rise"}, c);
        if (pulse_ready) dout_ready = 1'b0;
        check({name, "_rise_lat"}, c, 1);
        high = 1;
        repeat (dly) begin
            step();
            if (fifo_rd === 1'b1) high++;
        end
        fifo_empty   = 1'b1;
        fifo_dataout = BW'($urandom);
        wait_rd(1'b0, 20, {name, "_fall"}, c);
        high += (c > 0) ? c - 1 : 0;
        exp_high = (dly + 1 > RD_HOLD) ? dly + 1 : RD_HOLD;
        check({name, "_rd_high"}, high, exp_high);
    endtask

    initial begin
        int unsigned c;
        int unsigned pops0;
        int unsigned rd_seen;

        vecs[0] = '{data: 16'h1234, dly: 0, ready: 1'b1, exp_words: 16'd2};
        vecs[1] = '{data: 16'hBEEF, dly: 1, ready: 1'b1, exp_words: 16'd3};
        vecs[2] = '{data: 16'h0000, dly: 5, ready: 1'b1, exp_words: 16'd4};
        vecs[3] = '{data: 16'hFFFF, dly: 2, ready: 1'b1, exp_words: 16'd5};
        vecs[4] = '{data: 16'h8001, dly: 0, ready: 1'b0, exp_words: 16'd6};

        rst_n        = 1'b0;
        fifo_empty   = 1'b1;
        fifo_dataout = '0;
        dout_ready   = 1'b0;
        step(2);
        check("rst_rd", fifo_rd, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_words", words_rcvd, 0);
        check("rst_err", timeout_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single word, empty rises three cycles after fifo_rd, consumer stalled.
        send_word(16'hA5A5, 3, 1'b0, "single");
        check("single_valid", dout_valid, 1);
        check("single_dout_hold", dout, 16'hA5A5);
        check("single_words", words_rcvd, 1);
        dout_ready = 1'b1;
        step();
        check("single_drained", dout_valid, 0);

        // Table of round trips, including a 5-cycle late empty.
        for (int i = 0; i < 5; i++) begin
            dout_ready = vecs[i].ready;
            send_word(vecs[i].data, vecs[i].dly, 1'b0, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_words", i), words_rcvd, vecs[i].exp_words);
        end
        dout_ready = 1'b1;
        step();
        check("tbl_drained", dout_valid, 0);

        // Consumer stall: two words buffered, third must wait for space.
        dout_ready = 1'b0;
        send_word(16'h0001, 0, 1'b0, "stall1");
        send_word(16'h0002, 0, 1'b0, "stall2");
        exp_q.push_back(16'h0003);
        fifo_dataout = 16'h0003;
        fifo_empty   = 1'b0;
        rd_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (fifo_rd !== 1'b0) rd_seen++;
        end
        check("stall_no_ack", rd_seen, 0);
        check("stall_head", dout, 16'h0001);
        check("stall_words", words_rcvd, 8);
        dout_ready = 1'b1;
        wait_rd(1'b1, 20, "stall3_rise", c);
        fifo_empty = 1'b1;
        wait_rd(1'b0, 20, "stall3_fall", c);
        step(3);
        check("stall_drained", dout_valid, 0);
        check("stall_sb_empty", exp_q.size(), 0);
        check("stall_words_end", words_rcvd, 9);

        // Full buffer with a pop in every capture cycle over 20 words.
        dout_ready = 1'b0;
        send_word(16'h1111, 0, 1'b0, "fill1");
        send_word(16'h2222, 0, 1'b0, "fill2");
        pops0 = n_pops;
        for (int i = 0; i < 20; i++) begin
            send_word(16'($urandom), $urandom_range(0, 2), 1'b1, $sformatf("full%0d", i));
        end
        check("full_pops", n_pops - pops0, 20);
        check("full_still_valid", dout_valid, 1);
        check("full_words", words_rcvd, 31);
        dout_ready = 1'b1;
        step(3);
        check("full_sb_empty", exp_q.size(), 0);
        check("full_drained", dout_valid, 0);

`ifdef FIFO_READER_TIMEOUT_EN
        // Watchdog: empty never rises, fifo_rd must drop after 8 ACK cycles.
        exp_q.push_back(16'h5A5A);
        fifo_dataout = 16'h5A5A;
        fifo_empty   = 1'b0;
        wait_rd(1'b1, 20, "to_rise", c);
        wait_rd(1'b0, 20, "to_fall", c);
        fifo_empty = 1'b1;
        check("to_rd_high", c, 8);
        check("to_err", timeout_err, 1);
        check("to_words", words_rcvd, 32);
        step(3);
        check("to_err_sticky", timeout_err, 1);
        check("to_rd_low", fifo_rd, 0);
        check("to_sb_empty", exp_q.size(), 0);
`endif

        // Async reset in the middle of an ACK handshake.
        dout_ready = 1'b0;
        exp_q.push_back(16'hC3C3);
        fifo_dataout = 16'hC3C3;
        fifo_empty   = 1'b0;
        wait_rd(1'b1, 20, "ar_rise", c);
        check("ar_pre_valid", dout_valid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("ar_rd", fifo_rd, 0);
        check("ar_valid", dout_valid, 0);
        check("ar_dout", dout, 0);
        check("ar_words", words_rcvd, 0);
        check("ar_err", timeout_err, 0);
        fifo_empty = 1'b1;
        step(2);
        @(negedge clk);
        rst_n = 1'b1;
        step(2);
        check("ar_post_valid", dout_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Single-clock read-side agent for the 1-word clock-crossing FIFO, running in that FIFO's output (read) clock domain. It detects a valid word (empty low), captures it into a 2-entry output buffer, and drives the FIFO's `rd` level handshake until the FIFO reports empty again. It then presents captured words downstream on a valid/ready stream. The block turns the FIFO's level-based read protocol into a standard streaming interface for slow-domain consumers such as the host-side bus bridge.

## Interface
- `BUS_WIDTH`, 16, data word width; must match the FIFO.
- `RD_HOLD`, 2, minimum cycles `fifo_rd` stays high per handshake (≥1).
- `TIMEOUT`, 64, cycles in ACK before the watchdog fires (macro build only, ≥ RD_HOLD+1).

- `clk` in 1: single clock, the same as the FIFO read clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `fifo_dataout` in BUS_WIDTH: FIFO read data; valid while `fifo_empty` is low.
- `fifo_empty` in 1: FIFO empty flag; low means a word is readable.
- `fifo_rd` out 1: read acknowledge level to the FIFO; registered.
- `dout` out BUS_WIDTH: buffer head word.
- `dout_valid` out 1: buffer non-empty.
- `dout_ready` in 1: consumer accepts the head word when it is high together with `dout_valid`.
- `words_rcvd` out 16: count of captured words; wraps from 0xFFFF to 0.
- `timeout_err` out 1: sticky watchdog flag; constant 0 when the watchdog is compiled out.

## Operation
- The FSM has two states: IDLE and ACK.
- IDLE:
  - If `fifo_empty`=0 and the buffer has space (fewer than 2 entries, counted after this cycle's pop), push `fifo_dataout`.
  - In the same cycle, increment `words_rcvd`, set `fifo_rd`<=1, clear the hold/watchdog counter, and go to ACK.
  - Otherwise stay in IDLE. `fifo_rd` stays 0 and the FIFO remains full, which back-pressures the writer.
- ACK:
  - `fifo_rd` is held at 1 and the counter increments.
  - When `fifo_empty`=1 and the counter ≥ RD_HOLD-1: set `fifo_rd`<=0 and go to IDLE.
  - `fifo_empty` still reading low during ACK (synchroniser latency) never causes a second capture.
- Buffer:
  - 2 entries, in-order.
  - Push and pop in the same cycle are legal, including when the buffer is full and popping.
  - `dout` holds its value while `dout_valid`=1 and `dout_ready`=0.
- Reset: async entry to IDLE.
  - `fifo_rd`=0, `dout_valid`=0, `dout`=0, `words_rcvd`=0, `timeout_err`=0, buffer emptied.
  - Reset during ACK drops `fifo_rd` immediately; the FIFO recovers through its own reset.

## Timing
- Capture latency: `fifo_empty` falls at cycle N → word is on `dout`/`dout_valid` at N+1 (if the buffer was empty) → `fifo_rd` rises at N+1.
- `fifo_rd` falls on the cycle after `fifo_empty`=1 is sampled in ACK, but no earlier than RD_HOLD cycles after it rose.
- The earliest next capture is on the cycle after returning to IDLE.
- Throughput is one word per FIFO round trip; the buffer only absorbs consumer stalls.
- `dout_valid` depends only on registered state and never combinationally on `dout_ready`.
- All outputs are registered.

## Configuration
- Macro: `FIFO_READER_TIMEOUT_EN`.
- Defined:
  - In ACK, if the counter reaches TIMEOUT-1 with `fifo_empty` still 0, set `timeout_err`<=1 (sticky until reset), drop `fifo_rd`, and return to IDLE.
  - The captured word is kept, not rolled back.
- Undefined:
  - ACK waits indefinitely for `fifo_empty`.
  - `timeout_err` is tied to 0.
  - The counter width is sized by RD_HOLD only.

## Structure
- Shared package `fifo_reader_pkg` holds:
  - state encoding localparams (IDLE=1'b0, ACK=1'b1);
  - the counter-width function (clog2 of max(RD_HOLD, TIMEOUT));
  - the buffer depth constant (2).
- Sub-module `fifo_reader_buf`: the 2-entry valid/ready buffer, with ports push, push_data, pop, head, count, and not-full.
- The FSM, counter and watchdog live in the top module.

## Test plan
- Reset then a single word: drive `fifo_empty`=0 with 0xA5A5, and set `fifo_empty`=1 three cycles after `fifo_rd` rises → `dout`=0xA5A5 with `dout_valid`=1 one cycle later, `fifo_rd` high for ≥2 cycles then low, `words_rcvd`=1.
- Consumer stall: hold `dout_ready`=0 while feeding 0x0001, 0x0002, 0x0003 → first two buffered; third not acknowledged (`fifo_rd` stays 0). Release `dout_ready` → output order 1, 2, 3 and `words_rcvd`=3.
- Late-empty: keep `fifo_empty`=0 for 5 cycles of ACK → exactly one push, and `fifo_rd` stays high until empty rises.
- Simultaneous push/pop with the buffer full and `dout_ready`=1 → count stays 2, no word lost or duplicated over 20 words.
- With `FIFO_READER_TIMEOUT_EN` and TIMEOUT=8: hold `fifo_empty`=0 → `timeout_err`=1 at the 8th ACK cycle, `fifo_rd`=0, and the flag stays set until `rst_n` asserts mid-test, which clears all outputs asynchronously.
